// File: rtl/register_writeback.sv
// register_writeback: write end of the architectural register file.
// A single-entry holding latch takes the writeback bundle from the
// memory-access stage. The result is chosen from the ALU result, the load
// data or the return address, and the destination is rd or r15. The latched
// write commits one edge after it is accepted unless rf_freeze holds it.
// Two combinational read ports and a dedicated r15 port forward the
// committing value in the same cycle.
//
// Handshake (valid/ready): a bundle transfers on a rising edge where
// wb_valid && wb_ready. The producer keeps wb_valid and the bundle stable
// until that edge. wb_ready does not depend on wb_valid. wb_ready is high
// when the latch is empty, or when it is full and commits on this edge, so
// back-to-back bundles can stream at one per cycle. The latch commits when
// it is full and rf_freeze is low.
module register_writeback #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [31:0]       wb_inst,
  input  logic [31:0]       wb_pc,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_ld_result,
  input  logic              isWb,
  input  logic              isLd,
  input  logic              isCall,
  input  logic              rf_freeze,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] reg_data1,
  output logic [DATA_W-1:0] reg_data2,
  output logic [DATA_W-1:0] reg_data15,
  output logic              wr_pending,
  output logic [ADDR_W-1:0] wr_pending_addr,
  output logic              addr_err,
  output logic [15:0]       retire_count
);

  // Index width into the physical array. Addresses at or above NUM_REGS
  // never reach the array, because writes to them are dropped and reads
  // of them return zero.
  localparam int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] RA_ADDR   = ADDR_W'(15);
  localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  // True when an encoded register address maps onto a physical register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < REG_LIMIT);
  endfunction

  // Architectural registers.
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Holding latch.
  logic              full;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_dest;
  logic [DATA_W-1:0] lat_data;

  // Handshake terms.
  logic accept;
  logic commit;

  // Capture-side decode of the incoming bundle.
  logic [DATA_W-1:0] cap_data;
  logic [ADDR_W-1:0] cap_dest;
  logic              cap_we;

  // Forwarding of the value that commits this cycle.
  logic fwd_en;

  // Raw array reads before forwarding.
  logic [DATA_W-1:0] raw1;
  logic [DATA_W-1:0] raw2;
  logic [DATA_W-1:0] raw15;

  // Only rd is decoded from the instruction word. The rest of the word is
  // folded into one signal so that it has a reader.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{wb_inst[31:27], wb_inst[21:0]};

  // Handshake. A frozen full latch blocks both the commit and new bundles.
  always_comb begin
    commit   = full && !rf_freeze;
    wb_ready = !full || commit;
    accept   = wb_valid && wb_ready;
  end

  // Result and destination selection for the incoming bundle.
  // A call wins over a load, and a load wins over the ALU result.
  always_comb begin
    cap_data = wb_alu_result;
    cap_dest = ADDR_W'(wb_inst[26:22]);
    cap_we   = isWb || isCall;
    if (isCall) begin
      cap_data = DATA_W'(wb_pc + 32'd4);
      cap_dest = RA_ADDR;
    end else if (isLd) begin
      cap_data = wb_ld_result;
    end
  end

  // Holding latch: refill on accept (even while committing), else drain on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      lat_we   <= 1'b0;
      lat_dest <= '0;
      lat_data <= '0;
    end else if (accept) begin
      full     <= 1'b1;
      lat_we   <= cap_we;
      lat_dest <= cap_dest;
      lat_data <= cap_data;
    end else if (commit) begin
      full <= 1'b0;
    end
  end

  // Commit of the latched write into the array, with retire and error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      addr_err     <= 1'b0;
      retire_count <= 16'd0;
    end else if (commit && lat_we) begin
      if (addr_ok(lat_dest)) begin
        regs[lat_dest[IDX_W-1:0]] <= lat_data;
        retire_count              <= retire_count + 16'd1;
      end else begin
        addr_err <= 1'b1;
      end
    end
  end

  // Hazard visibility. A held write to an out-of-range register is still
  // reported so that the fetch side sees a consistent picture.
  always_comb begin
    wr_pending      = full && lat_we;
    wr_pending_addr = full ? lat_dest : '0;
  end

  // Read ports. A value is forwarded only while it commits. A frozen entry
  // is not forwarded because its write has not happened yet.
  always_comb begin
    fwd_en = commit && lat_we && addr_ok(lat_dest);
    raw1   = addr_ok(rd_addr1) ? regs[rd_addr1[IDX_W-1:0]] : '0;
    raw2   = addr_ok(rd_addr2) ? regs[rd_addr2[IDX_W-1:0]] : '0;
    raw15  = addr_ok(RA_ADDR)  ? regs[RA_ADDR[IDX_W-1:0]]  : '0;

    reg_data1  = (fwd_en && (lat_dest == rd_addr1)) ? lat_data : raw1;
    reg_data2  = (fwd_en && (lat_dest == rd_addr2)) ? lat_data : raw2;
    reg_data15 = (fwd_en && (lat_dest == RA_ADDR))  ? lat_data : raw15;
  end

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback. A cycle-by-cycle vector table is
// followed by hand-written sequences for reset during a freeze and for
// streaming into the same register.
module tb_register_writeback;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 5;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_inst;
  logic [31:0]       wb_pc;
  logic [DATA_W-1:0] wb_alu_result;
  logic [DATA_W-1:0] wb_ld_result;
  logic              isWb;
  logic              isLd;
  logic              isCall;
  logic              rf_freeze;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] reg_data1;
  logic [DATA_W-1:0] reg_data2;
  logic [DATA_W-1:0] reg_data15;
  logic              wr_pending;
  logic [ADDR_W-1:0] wr_pending_addr;
  logic              addr_err;
  logic [15:0]       retire_count;

  register_writeback #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_inst        (wb_inst),
    .wb_pc          (wb_pc),
    .wb_alu_result  (wb_alu_result),
    .wb_ld_result   (wb_ld_result),
    .isWb           (isWb),
    .isLd           (isLd),
    .isCall         (isCall),
    .rf_freeze      (rf_freeze),
    .rd_addr1       (rd_addr1),
    .rd_addr2       (rd_addr2),
    .reg_data1      (reg_data1),
    .reg_data2      (reg_data2),
    .reg_data15     (reg_data15),
    .wr_pending     (wr_pending),
    .wr_pending_addr(wr_pending_addr),
    .addr_err       (addr_err),
    .retire_count   (retire_count)
  );

  // One vector is one cycle. The inputs are driven after the falling edge
  // and the outputs are checked before the next rising edge.
  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        wb;
    logic        lds;
    logic        call;
    logic        frz;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        e_ready;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic [31:0] e_d15;
    logic        e_pend;
    logic [4:0]  e_paddr;
    logic        e_err;
    logic [15:0] e_rc;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  function automatic vec_t mk(
    input logic valid, input logic [4:0] rd, input logic [31:0] pc,
    input logic [31:0] alu, input logic [31:0] ld, input logic wb,
    input logic lds, input logic call, input logic frz,
    input logic [4:0] a1, input logic [4:0] a2,
    input logic e_ready, input logic [31:0] e_d1, input logic [31:0] e_d2,
    input logic [31:0] e_d15, input logic e_pend, input logic [4:0] e_paddr,
    input logic e_err, input logic [15:0] e_rc);
    vec_t v;
    v.valid = valid; v.rd = rd; v.pc = pc; v.alu = alu; v.ld = ld;
    v.wb = wb; v.lds = lds; v.call = call; v.frz = frz; v.a1 = a1; v.a2 = a2;
    v.e_ready = e_ready; v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_d15 = e_d15;
    v.e_pend = e_pend; v.e_paddr = e_paddr; v.e_err = e_err; v.e_rc = e_rc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a bundle. The bits of wb_inst outside the rd field are random.
  task automatic drive(input logic valid, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] ld, input logic wb,
                       input logic lds, input logic call, input logic frz);
    logic [31:0] inst;
    inst          = $urandom;
    inst[26:22]   = rd;
    wb_valid      = valid;
    wb_inst       = inst;
    wb_pc         = pc;
    wb_alu_result = alu;
    wb_ld_result  = ld;
    isWb          = wb;
    isLd          = lds;
    isCall        = call;
    rf_freeze     = frz;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state: every register reads zero, the latch is empty, the counters are clear.
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(NUM_REGS - 1 - i);
      #1;
      check($sformatf("reset rd1[%0d]", i), reg_data1, 32'd0);
      check($sformatf("reset rd2[%0d]", NUM_REGS - 1 - i), reg_data2, 32'd0);
    end
    check("reset ready", {31'd0, wb_ready}, 32'd1);
    check("reset pend", {31'd0, wr_pending}, 32'd0);
    check("reset paddr", {27'd0, wr_pending_addr}, 32'd0);
    check("reset err", {31'd0, addr_err}, 32'd0);
    check("reset rc", {16'd0, retire_count}, 32'd0);
    check("reset r15", reg_data15, 32'd0);

    //          vld rd  pc      alu           ld         wb lds cal frz a1  a2   rdy d1            d2            d15        pnd pad err rc
    vecs.push_back(mk(1, 3, 0,      32'hDEADBEEF, 0,         1, 0, 0, 0, 3,  0,   1, 0,            0,            0,         0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0,      0,            0,         0, 0, 0, 0, 3,  3,   1, 32'hDEADBEEF, 32'hDEADBEEF, 0,         1, 3,  0, 0));
    vecs.push_back(mk(1, 0, 32'h100, 32'h777,     32'h888,   0, 0, 1, 0, 3,  15,  1, 32'hDEADBEEF, 0,            0,         0, 0,  0, 1));
    vecs.push_back(mk(1, 7, 0,      32'h99,       32'h55,    1, 1, 0, 0, 15, 7,   1, 32'h104,      0,            32'h104,   1, 15, 0, 1));
    vecs.push_back(mk(0, 0, 0,      0,            0,         0, 0, 0, 0, 7,  15,  1, 32'h55,       32'h104,      32'h104,   1, 7,  0, 2));
    vecs.push_back(mk(1, 5, 0,      32'hAAAA5555, 0,         1, 0, 0, 0, 5,  7,   1, 0,            32'h55,       32'h104,   0, 0,  0, 3));
    vecs.push_back(mk(1, 6, 0,      32'h666,      0,         1, 0, 0, 1, 5,  6,   0, 0,            0,            32'h104,   1, 5,  0, 3));
    vecs.push_back(mk(1, 6, 0,      32'h666,      0,         1, 0, 0, 1, 5,  6,   0, 0,            0,            32'h104,   1, 5,  0, 3));
    vecs.push_back(mk(0, 0, 0,      0,            0,         0, 0, 0, 0, 5,  6,   1, 32'hAAAA5555, 0,            32'h104,   1, 5,  0, 3));
    vecs.push_back(mk(1, 2, 0,      1,            0,         1, 0, 0, 0, 2,  5,   1, 0,            32'hAAAA5555, 32'h104,   0, 0,  0, 4));
    vecs.push_back(mk(1, 2, 0,      2,            0,         1, 0, 0, 0, 2,  5,   1, 1,            32'hAAAA5555, 32'h104,   1, 2,  0, 4));
    vecs.push_back(mk(1, 2, 0,      3,            0,         1, 0, 0, 0, 2,  5,   1, 2,            32'hAAAA5555, 32'h104,   1, 2,  0, 5));
    vecs.push_back(mk(0, 0, 0,      0,            0,         0, 0, 0, 0, 2,  5,   1, 3,            32'hAAAA5555, 32'h104,   1, 2,  0, 6));
    vecs.push_back(mk(0, 0, 0,      0,            0,         0, 0, 0, 0, 2,  5,   1, 3,            32'hAAAA5555, 32'h104,   0, 0,  0, 7));
    vecs.push_back(mk(1, 9, 0,      32'h1234,     0,         0, 0, 0, 0, 9,  2,   1, 0,            3,            32'h104,   0, 0,  0, 7));
    vecs.push_back(mk(0, 0, 0,      0,            0,         0, 0, 0, 0, 9,  2,   1, 0,            3,            32'h104,   0, 9,  0, 7));
    vecs.push_back(mk(1, 20, 0,     32'hBAD,      0,         1, 0, 0, 0, 20, 2,   1, 0,            3,            32'h104,   0, 0,  0, 7));
    vecs.push_back(mk(0, 0, 0,      0,            0,         0, 0, 0, 0, 20, 2,   1, 0,            3,            32'h104,   1, 20, 0, 7));
    vecs.push_back(mk(0, 0, 0,      0,            0,         0, 0, 0, 0, 4,  2,   1, 0,            3,            32'h104,   0, 0,  1, 7));
    vecs.push_back(mk(0, 0, 0,      0,            0,         0, 0, 0, 0, 15, 7,   1, 32'h104,      32'h55,       32'h104,   0, 0,  1, 7));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].rd, vecs[i].pc, vecs[i].alu, vecs[i].ld,
            vecs[i].wb, vecs[i].lds, vecs[i].call, vecs[i].frz);
      rd_addr1 = vecs[i].a1;
      rd_addr2 = vecs[i].a2;
      #1;
      check($sformatf("v%0d ready", i), {31'd0, wb_ready}, {31'd0, vecs[i].e_ready});
      check($sformatf("v%0d data1", i), reg_data1, vecs[i].e_d1);
      check($sformatf("v%0d data2", i), reg_data2, vecs[i].e_d2);
      check($sformatf("v%0d data15", i), reg_data15, vecs[i].e_d15);
      check($sformatf("v%0d pend", i), {31'd0, wr_pending}, {31'd0, vecs[i].e_pend});
      check($sformatf("v%0d paddr", i), {27'd0, wr_pending_addr}, {27'd0, vecs[i].e_paddr});
      check($sformatf("v%0d err", i), {31'd0, addr_err}, {31'd0, vecs[i].e_err});
      check($sformatf("v%0d rc", i), {16'd0, retire_count}, {16'd0, vecs[i].e_rc});
    end

    // Reset asserted while a frozen entry is held discards the entry.
    @(negedge clk);
    drive(1'b1, 5'd8, 32'd0, 32'h88, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rd_addr1 = 5'd8;
    rd_addr2 = 5'd15;
    #1;
    check("hold ready", {31'd0, wb_ready}, 32'd0);
    check("hold pend", {31'd0, wr_pending}, 32'd1);
    check("hold paddr", {27'd0, wr_pending_addr}, 32'd8);
    check("hold r8", reg_data1, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst pend", {31'd0, wr_pending}, 32'd0);
    check("rst paddr", {27'd0, wr_pending_addr}, 32'd0);
    check("rst ready", {31'd0, wb_ready}, 32'd1);
    check("rst err", {31'd0, addr_err}, 32'd0);
    check("rst rc", {16'd0, retire_count}, 32'd0);
    check("rst r15", reg_data2, 32'd0);
    check("rst r15 port", reg_data15, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    #1;
    check("post rst r8", reg_data1, 32'd0);
    check("post rst pend", {31'd0, wr_pending}, 32'd0);
    check("post rst rc", {16'd0, retire_count}, 32'd0);

    // Streaming into one register: each commit cycle must forward the oldest outstanding value.
    rd_addr1 = 5'd2;
    for (int c = 0; c < 4; c++) begin
      logic [31:0] val;
      @(negedge clk);
      val = 32'h11 * (c + 1);
      if (c < 3) drive(1'b1, 5'd2, 32'd0, val, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      else idle();
      #1;
      check($sformatf("stream ready %0d", c), {31'd0, wb_ready}, 32'd1);
      if (c > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream queue %0d: got empty expected entry", c);
        end else begin
          check($sformatf("stream fwd %0d", c), reg_data1, exp_q.pop_front());
        end
      end
      if (c < 3) exp_q.push_back(val);
    end
    @(negedge clk);
    #1;
    check("stream final r2", reg_data1, 32'h33);
    check("stream final rc", {16'd0, retire_count}, 32'd3);
    check("stream queue drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_writeback.md
Name: register_writeback

Overview:
- Write end of the register file: accepts the writeback bundle from the memory-access stage and selects the result (ALU, load, or return address for call).
- Resolves the destination (rd, or r15 for call) and commits it to the architectural register array.
- Serves the combinational read ports consumed by the register-fetch stage, with same-cycle write-through forwarding.
- Includes a single-entry holding latch with valid/ready handshake and a freeze input for debug halt.

Parameters:
- DATA_W, 32, datapath and register width
- NUM_REGS, 16, number of architectural registers (r15 = return address)
- ADDR_W, 5, register address width as encoded in the instruction

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wb_valid  input  1  writeback bundle valid
- wb_ready  output  1  latch can accept a bundle this cycle
- wb_inst  input  32  instruction; rd = wb_inst[26:22]
- wb_pc  input  32  PC of the instruction
- wb_alu_result  input  DATA_W  ALU result
- wb_ld_result  input  DATA_W  load data
- isWb  input  1  instruction writes a register
- isLd  input  1  select load data
- isCall  input  1  write PC+4 into r15
- rf_freeze  input  1  block commit (entry held)
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- reg_data1  output  DATA_W  read port 1 data
- reg_data2  output  DATA_W  read port 2 data
- reg_data15  output  DATA_W  r15 dedicated read
- wr_pending  output  1  latch holds an uncommitted write
- wr_pending_addr  output  ADDR_W  destination of held write
- addr_err  output  1  sticky: a write to an address >= NUM_REGS was dropped
- retire_count  output  16  count of committed register writes

Behaviour:
- Reset (async, rst_n=0):
  - all registers = 0
  - latch empty; wr_pending = 0; wr_pending_addr = 0
  - addr_err = 0; retire_count = 0
  - reset mid-hold discards the held entry
- Handshake:
  - accept = wb_valid && wb_ready
  - commit = full && !rf_freeze
  - wb_ready = !full || commit; a new bundle can be accepted in the same cycle the old one commits
- Capture (on accept, registered):
  - data = isCall ? wb_pc+4 (mod 2^32) : isLd ? wb_ld_result : wb_alu_result
  - dest = isCall ? 15 : wb_inst[26:22]
  - we = isWb || isCall
  - Bundles with we=0 are still latched and occupy one commit cycle but write nothing.
- Commit (registered, latency 1 cycle after accept when unfrozen):
  - if we and dest < NUM_REGS: reg[dest] <= data, retire_count += 1 (wraps at 16'hFFFF -> 0)
  - if we and dest >= NUM_REGS: no write, addr_err <= 1 (sticky until reset)
  - latch clears unless refilled in the same cycle.
- Freeze: while rf_freeze=1 and full, the entry is held and wb_ready = 0. Deasserting freeze commits on the next edge.
- wr_pending = full && we; wr_pending_addr = dest when full, else 0.
- Reads (combinational):
  - reg_dataN = (commit && we && dest==rd_addrN && dest<NUM_REGS) ? latched data : reg[rd_addrN]
  - rd_addrN >= NUM_REGS reads 0
  - reg_data15 applies the same forwarding rule with address 15
  - No forwarding from a held (frozen) entry; hazard logic uses wr_pending.
- Simultaneous accept and commit to the same dest: the committed value is written; the new value sits in the latch, last-writer-wins on the next commit.

Test Plan:
- Reset then read all 16 addresses -> every reg_data = 0; wb_ready = 1; retire_count = 0.
- Accept isWb=1, inst rd=3, alu=0xDEADBEEF, rd_addr1=3 -> reg_data1 = 0xDEADBEEF in the commit cycle (forwarded) and on all later cycles; retire_count = 1.
- isCall=1, wb_pc=0x100 -> r15 = 0x104 and reg_data15 = 0x104; isLd=1, ld=0x55, rd=7 -> r7 = 0x55.
- rf_freeze=1 with latch full -> wb_ready = 0, wr_pending = 1, wr_pending_addr = 5, reg[5] unchanged. Release freeze -> commit next edge and wb_ready returns to 1.
- Back-to-back valid every cycle to rd=2 with values 1,2,3 -> r2 sequence 1,2,3, one commit per cycle, wb_ready constantly 1.
- rd field = 20 with isWb=1 -> no register changes, addr_err = 1 and stays 1. Assert rst_n=0 while a frozen entry is held -> entry discarded, addr_err = 0.
